parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Serial frame transmitter that sits directly downstream of the 8-bit parity generator. It accepts a data byte together with the parity bit computed for it, using a valid/ready handshake. It then shifts out one frame on a single line: start bit, data bits LSB first, parity bit, stop bit. Each bit is held for a programmable number of clock cycles.

Parameters:
DATA_W, 8, payload width in bits
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range 1..256

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_W  payload byte to transmit
parity_in  input  1  parity bit for data_in, driven by the upstream parity generator
in_valid  input  1  data_in/parity_in valid
in_ready  output  1  block can accept a frame this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of the final stop bit

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values (apply immediately on rst assertion, independent of clk): tx=1, in_ready=1, busy=0, frame_done=0, state=IDLE, all counters 0.
- Acceptance rule: a frame is accepted at a rising edge where in_valid=1 and in_ready=1.
  - data_in and parity_in are latched into a shift register on that edge.
  - Inputs are ignored at all other times, and changes to them while busy have no effect.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - Outputs: tx=1, in_ready=1, busy=0.
  - On acceptance, go to START. From the next cycle: tx=0, in_ready=0, busy=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - A bit counter runs 0..DATA_W-1. After bit DATA_W-1 completes, go to PARITY.
- PARITY: tx = latched parity_in for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle's edge: go to IDLE, assert frame_done for exactly one cycle, and set in_ready=1 and busy=0 in that same cycle.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and is sized to hold CLKS_PER_BIT-1. It resets to 0 on every bit transition.
- CLKS_PER_BIT=1 is legal: every bit lasts one cycle, with no extra gap.
- Frame length: tx is low from the cycle after acceptance. The frame lasts (DATA_W+3)*CLKS_PER_BIT cycles, i.e. 44 cycles at the defaults.
- Back-to-back frames: if in_valid is held high, the next frame is accepted on the edge where frame_done is high, because in_ready is already 1 in that cycle. The next start bit then follows immediately after the stop bit, with no idle gap.
- Parity pass-through: parity_in is sent unmodified. The block does not recompute or check parity.
- Reset mid-frame: the frame is aborted and tx returns to 1 immediately. No frame_done pulse is produced. The block re-enters IDLE and the latched byte is discarded.
- All outputs are registered, with no combinational path from inputs to outputs. The exception is in_ready, which is a registered state decode.

Optional Feature:
Macro PARITY_FRAME_TX_STOP2_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles, giving two stop bits and a frame length of (DATA_W+4)*CLKS_PER_BIT cycles. frame_done pulses at the end of the second stop bit.
- Undefined: one stop bit, as described above.

Test Plan:
- Reset values: assert rst with no clock edge -> tx=1, in_ready=1, busy=0, frame_done=0 immediately.
- Single frame, data_in=8'h03, parity_in=0, CLKS_PER_BIT=4:
  - tx, sampled mid-bit every 4 cycles, reads 0,1,1,0,0,0,0,0,0,0,1.
  - busy is high for 44 cycles, and frame_done pulses once on cycle 44 after acceptance.
- Parity bit, data_in=8'h07, parity_in=1: parity slot reads 1 and the data bits read 1,1,1,0,0,0,0,0. Repeat with parity_in=0 to confirm pass-through.
- Back-to-back frames: hold in_valid=1 and send 8'h0F (parity 0) then 8'h1F (parity 1) -> the second start bit begins in the cycle right after the first stop bit ends. in_ready is high only on the frame_done cycle. Changing data_in mid-frame does not alter the tx stream.
- Reset mid-frame: pulse rst during the DATA bit-3 period -> tx=1 immediately and no frame_done. A fresh 8'h7F (parity 1) sent afterwards transmits correctly.
- With PARITY_FRAME_TX_STOP2_EN defined, CLKS_PER_BIT=1, data 8'h00, parity 0 -> tx reads 0,0,0,0,0,0,0,0,0,0,1,1. frame_done pulses on cycle 12 after acceptance.

Source files
------------

// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-output bundle for parity_frame_tx.
// master drives the byte/parity/valid side; slave is the transmitter.
interface parity_frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              parity_in;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic              frame_done;

  modport master (
    output data_in,
    output parity_in,
    output in_valid,
    input  in_ready,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  parity_in,
    input  in_valid,
    output in_ready,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, parity, stop; each bit held CLKS_PER_BIT clocks.
// Define PARITY_FRAME_TX_STOP2_EN to send two stop bits instead of one.
module parity_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  parity_frame_tx_if.slave  bus
);

  localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef PARITY_FRAME_TX_STOP2_EN
  localparam int unsigned STOP_BITS = 2;
`else
  localparam int unsigned STOP_BITS = 1;
`endif
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e              state_q,      state_d;
  logic [CYC_W-1:0]    cyc_q,        cyc_d;
  logic [BIT_W-1:0]    bit_q,        bit_d;
  logic [DATA_W-1:0]   shift_q,      shift_d;
  logic                par_q,        par_d;
  logic                stop_q,       stop_d;
  logic                tx_q,         tx_d;
  logic                in_ready_q,   in_ready_d;
  logic                busy_q,       busy_d;
  logic                frame_done_q, frame_done_d;

  logic                bit_end;
  logic [DATA_W-1:0]   shift_nxt;

  assign bit_end   = (cyc_q == CYC_LAST);
  assign shift_nxt = shift_q >> 1;

  // Next-state and next-output decode; tx is prepared one edge ahead of each bit.
  always_comb begin
    state_d      = state_q;
    cyc_d        = bit_end ? '0 : cyc_q + CYC_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_d       = stop_q;
    tx_d         = tx_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cyc_d      = '0;
        tx_d       = 1'b1;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          shift_d    = bus.data_in;
          par_d      = bus.parity_in;
          bit_d      = '0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_nxt;
            tx_d    = shift_nxt[0];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_q != STOP_LAST) begin
            stop_d = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
            in_ready_d   = 1'b1;
            busy_d       = 1'b0;
            tx_d         = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cyc_d      = '0;
        tx_d       = 1'b1;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      tx_q         <= 1'b1;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_q       <= stop_d;
      tx_q         <= tx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: literal frame table, hand-written corner sequences,
// and random frames checked against a slot-by-slot frame model.
module tb_parity_frame_tx;

  localparam int unsigned DATA_W = 8;
`ifdef PARITY_FRAME_TX_STOP2_EN
  localparam int unsigned CPB   = 1;
  localparam int unsigned STOPS = 2;
`else
  localparam int unsigned CPB   = 4;
  localparam int unsigned STOPS = 1;
`endif
  localparam int unsigned NSLOT     = DATA_W + 2 + STOPS;
  localparam int unsigned FRAME_LEN = NSLOT * CPB;

  logic clk;
  logic rst;

  parity_frame_tx_if #(.DATA_W(DATA_W)) bus ();

  parity_frame_tx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // head holds start, data and parity slots in time order; every later slot is a stop bit
  function automatic logic slot_bit(input logic [DATA_W+1:0] head, input int s);
    return (s < int'(DATA_W + 2)) ? head[s] : 1'b1;
  endfunction

  function automatic logic [DATA_W+1:0] model_head(input logic [DATA_W-1:0] d, input logic p);
    logic [DATA_W+1:0] h;
    int unsigned v;
    v = 32'(d);
    h = '0;
    for (int i = 0; i < int'(DATA_W); i++) h[i+1] = 1'((v / (32'd1 << i)) % 2);
    h[DATA_W+1] = p;
    return h;
  endfunction

  // Entered at a falling edge with in_valid/in_ready high, so the next rising edge accepts.
  task automatic run_frame(input logic [DATA_W+1:0] head, input string name,
                           input logic nv, input logic [DATA_W-1:0] nd, input logic np);
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      @(negedge clk);
      check({name, " tx"}, 32'(bus.tx), 32'(slot_bit(head, k / int'(CPB))));
      check({name, " busy/rdy/done"}, 32'({bus.busy, bus.in_ready, bus.frame_done}), 32'(3'b100));
      bus.data_in   = DATA_W'($urandom);
      bus.parity_in = 1'($urandom);
    end
    @(negedge clk);
    check({name, " done tx"}, 32'(bus.tx), 32'd1);
    check({name, " done busy/rdy/done"}, 32'({bus.busy, bus.in_ready, bus.frame_done}), 32'(3'b011));
    bus.in_valid  = nv;
    bus.data_in   = nd;
    bus.parity_in = np;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, " idle tx"}, 32'(bus.tx), 32'd1);
    check({name, " idle busy/rdy/done"}, 32'({bus.busy, bus.in_ready, bus.frame_done}), 32'(3'b010));
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par;
    logic [DATA_W+1:0] head;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DATA_W-1:0] d, nd;
    logic              p, np, chain;
    int unsigned       gap;

    checks = 0;
    errors = 0;
    vecs[0] = '{data: 8'h03, par: 1'b0, head: 10'h006};
    vecs[1] = '{data: 8'h07, par: 1'b1, head: 10'h20E};
    vecs[2] = '{data: 8'h07, par: 1'b0, head: 10'h00E};
    vecs[3] = '{data: 8'h00, par: 1'b0, head: 10'h000};
    vecs[4] = '{data: 8'hA5, par: 1'b1, head: 10'h34A};
    vecs[5] = '{data: 8'hFF, par: 1'b0, head: 10'h1FE};
    vecs[6] = '{data: 8'h80, par: 1'b1, head: 10'h300};

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.parity_in = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset busy/rdy/done", 32'({bus.busy, bus.in_ready, bus.frame_done}), 32'(3'b010));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("post reset");

    foreach (vecs[i]) begin
      bus.data_in   = vecs[i].data;
      bus.parity_in = vecs[i].par;
      bus.in_valid  = 1'b1;
      run_frame(vecs[i].head, $sformatf("vec%0d", i), 1'b0, '0, 1'b0);
      check_idle($sformatf("vec%0d", i));
    end

    // Back-to-back with in_valid held: second frame accepted on the frame_done cycle
    bus.data_in   = 8'h0F;
    bus.parity_in = 1'b0;
    bus.in_valid  = 1'b1;
    run_frame(10'h01E, "b2b first", 1'b1, 8'h1F, 1'b1);
    run_frame(10'h23E, "b2b second", 1'b0, '0, 1'b0);
    check_idle("b2b");

    // Reset during data bit 3: line returns high at once and no frame_done follows
    bus.data_in   = 8'h3C;
    bus.parity_in = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    check("midrst in bit3 tx", 32'(bus.tx), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst tx", 32'(bus.tx), 32'd1);
    check("midrst busy/rdy/done", 32'({bus.busy, bus.in_ready, bus.frame_done}), 32'(3'b010));
    #1 rst = 1'b0;
    for (int k = 0; k < int'(FRAME_LEN) + 2; k++) begin
      @(negedge clk);
      check("midrst no done", 32'({bus.tx, bus.busy, bus.frame_done}), 32'(3'b100));
    end
    bus.data_in   = 8'h7F;
    bus.parity_in = 1'b1;
    bus.in_valid  = 1'b1;
    run_frame(10'h2FE, "after rst", 1'b0, '0, 1'b0);
    check_idle("after rst");

    // Random frames, randomly chained back-to-back or separated by idle cycles
    d = DATA_W'($urandom);
    p = 1'($urandom);
    bus.data_in   = d;
    bus.parity_in = p;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      nd    = DATA_W'($urandom);
      np    = 1'($urandom);
      chain = (i < 23) ? 1'($urandom) : 1'b0;
      run_frame(model_head(d, p), $sformatf("rand%0d", i), chain, nd, np);
      if (!chain) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= int'(gap); g++) check_idle($sformatf("rand%0d", i));
        bus.in_valid = (i < 23);
      end
      d = nd;
      p = np;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
